// File: rtl/led_sb_ctrl.sv
// Bus-mapped LED output peripheral: 16 LEDs driven steadily or blinking,
// with a hardware blink timer, soft-reset register and registered reads.
module led_sb_ctrl #(
    parameter int unsigned BLINK_HALF_PERIOD = 10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic [15:0] led_o
);

    localparam int unsigned CNT_W = $clog2(2 * BLINK_HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * BLINK_HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_HALF_PERIOD);

    localparam logic [31:0] ADDR_VAL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_MODE  = 32'h0000_0004;
    localparam logic [31:0] ADDR_SRST  = 32'h0000_0024;
    localparam logic [31:0] SRST_MAGIC = 32'h0000_0001;

    logic [15:0]      led_val;
    logic             led_mode;
    logic [CNT_W-1:0] cnt;

    logic        wr;
    logic        rd;
    logic        soft_rst;
    logic        rd_hit;
    logic [31:0] rd_val;

    assign wr       = req_i && write_enable_i;
    assign rd       = req_i && !write_enable_i;
    assign soft_rst = wr && (addr_i == ADDR_SRST) && (write_data_i == SRST_MAGIC);

    always_comb begin
        rd_hit = 1'b1;
        rd_val = '0;
        unique case (addr_i)
            ADDR_VAL:  rd_val = {16'h0000, led_val};
            ADDR_MODE: rd_val = {31'h0, led_mode};
            ADDR_SRST: rd_val = '0;
            default:   rd_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            led_val     <= '0;
            led_mode    <= 1'b0;
            cnt         <= '0;
            read_data_o <= '0;
        end else begin
            if (rd && rd_hit) begin
                read_data_o <= rd_val;
            end

            // Soft reset outranks the normal counter advance; any write to the
            // mode register restarts the blink phase even if the value is unchanged.
            if (soft_rst) begin
                led_val  <= '0;
                led_mode <= 1'b0;
                cnt      <= '0;
            end else begin
                if (wr && (addr_i == ADDR_VAL)) begin
                    led_val <= write_data_i[15:0];
                end

                if (wr && (addr_i == ADDR_MODE)) begin
                    led_mode <= write_data_i[0];
                    cnt      <= '0;
                end else if (!led_mode || (cnt == CNT_LAST)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        led_o = led_val;
        if (led_mode && (cnt >= CNT_HALF)) begin
            led_o = '0;
        end
    end

endmodule
